// File: rtl/mux_pkg.sv
// Shared select type and select-code constants for the registered 4:1 mux.
package mux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_I0 = 2'b00;
   localparam sel_t SEL_I1 = 2'b01;
   localparam sel_t SEL_I2 = 2'b10;
   localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational WIDTH-bit 4:1 selector; sel = {s1,s0}.
import mux_pkg::*;

module mux4_comb #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  sel_t             sel,
   output logic [WIDTH-1:0] y
);

   // X default: an unknown select propagates as all-X rather than aliasing to i0,
   // and lets synthesis treat the case as full.
   always_comb begin
      y = 'x;
      case (sel)
         SEL_I0: y = i0;
         SEL_I1: y = i1;
         SEL_I2: y = i2;
         SEL_I3: y = i3;
      endcase
   end

endmodule

// File: rtl/mux_4in.sv
// Registered 4:1 multiplexer: selected input appears on out one clock later.
import mux_pkg::*;

module mux_4in #(
   parameter int unsigned    WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] out
);

   sel_t             sel;
   logic [WIDTH-1:0] sel_data;

   assign sel = {s1, s0};

   mux4_comb #(
      .WIDTH (WIDTH)
   ) u_sel (
      .i0  (i0),
      .i1  (i1),
      .i2  (i2),
      .i3  (i3),
      .sel (sel),
      .y   (sel_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= RESET_VAL;
      end else begin
         out <= sel_data;
      end
   end

endmodule

// File: tb/tb_mux_4in.sv
// Self-checking bench for mux_4in at WIDTH=8 against an array-indexed reference.
module tb_mux_4in;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din [4];
   logic [1:0]   sel;
   logic [W-1:0] i0, i1, i2, i3;
   logic [W-1:0] out;
   logic [W-1:0] exp_v;
   int           total;
   int           bad;

   assign i0 = din[0];
   assign i1 = din[1];
   assign i2 = din[2];
   assign i3 = din[3];

   mux_4in #(
      .WIDTH     (W),
      .RESET_VAL (8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i0    (i0),
      .i1    (i1),
      .i2    (i2),
      .i3    (i3),
      .s1    (sel[1]),
      .s0    (sel[0]),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [W-1:0] v);
      for (int k = 0; k < 4; k++) din[k] = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_all('0);
      din[0] = 8'h01;
      sel = 2'b00;
      #1;
      total++;
      if (out !== 8'h00) begin
         bad++;
         $display("FAIL reset_async: got %h want %h", out, 8'h00);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if (out !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold cyc%0d: got %h want %h", c, out, 8'h00);
         end
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (out !== 8'h01) begin
         bad++;
         $display("FAIL reset_release: got %h want %h", out, 8'h01);
      end
   endtask

   task automatic test_zeros();
      set_all('0);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         total++;
         if (out !== 8'h00) begin
            bad++;
            $display("FAIL zeros sel=%0d: got %h want %h", s, out, 8'h00);
         end
      end
   endtask

   task automatic test_one_hot();
      for (int s = 0; s < 4; s++) begin
         set_all('0);
         din[s] = 8'h01;
         sel = 2'(s);
         #2;
         exp_v = (s == 0) ? 8'h00 : 8'h00;
         total++;
         if (out !== 8'h00) begin
            bad++;
            $display("FAIL one_hot_early sel=%0d: got %h want %h", s, out, exp_v);
         end
         tick();
         total++;
         if (out !== 8'h01) begin
            bad++;
            $display("FAIL one_hot sel=%0d: got %h want %h", s, out, 8'h01);
         end
         set_all('0);
         tick();
      end
   endtask

   task automatic test_isolation();
      set_all('0);
      sel = 2'b10;
      tick();
      for (int c = 0; c < 6; c++) begin
         din[0] = 8'($urandom);
         din[1] = 8'($urandom);
         din[3] = 8'($urandom);
         tick();
         total++;
         if (out !== 8'h00) begin
            bad++;
            $display("FAIL isolation cyc%0d: got %h want %h", c, out, 8'h00);
         end
      end
      din[2] = 8'h01;
      tick();
      total++;
      if (out !== 8'h01) begin
         bad++;
         $display("FAIL isolation_sel: got %h want %h", out, 8'h01);
      end
   endtask

   task automatic test_same_edge();
      set_all('0);
      sel = 2'b00;
      tick();
      sel = 2'b11;
      din[3] = 8'h01;
      tick();
      total++;
      if (out !== 8'h01) begin
         bad++;
         $display("FAIL same_edge: got %h want %h", out, 8'h01);
      end
   endtask

   task automatic test_width();
      logic [W-1:0] pat [4];
      pat[0] = 8'hA5;
      pat[1] = 8'h3C;
      pat[2] = 8'hFF;
      pat[3] = 8'h00;
      for (int k = 0; k < 4; k++) din[k] = pat[k];
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         total++;
         if (out !== pat[s]) begin
            bad++;
            $display("FAIL width sel=%0d: got %h want %h", s, out, pat[s]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
         sel = 2'($urandom_range(0, 3));
         exp_v = din[sel];
         tick();
         total++;
         if (out !== exp_v) begin
            bad++;
            $display("FAIL random%0d sel=%0d: got %h want %h", n, sel, out, exp_v);
         end
         // Disturb every input mid-cycle; out must not move before the next edge.
         for (int k = 0; k < 4; k++) din[k] = ~din[k];
         sel = ~sel;
         #3;
         total++;
         if (out !== exp_v) begin
            bad++;
            $display("FAIL hold%0d: got %h want %h", n, out, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_all('0);
      din[3] = 8'h77;
      sel = 2'b11;
      tick();
      total++;
      if (out !== 8'h77) begin
         bad++;
         $display("FAIL mid_pre: got %h want %h", out, 8'h77);
      end
      din[3] = 8'h11;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out !== 8'h00) begin
         bad++;
         $display("FAIL mid_async: got %h want %h", out, 8'h00);
      end
      tick();
      total++;
      if (out !== 8'h00) begin
         bad++;
         $display("FAIL mid_hold: got %h want %h", out, 8'h00);
      end
      rst_n = 1'b1;
      din[3] = 8'h42;
      tick();
      total++;
      if (out !== 8'h42) begin
         bad++;
         $display("FAIL mid_release: got %h want %h", out, 8'h42);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      sel = 2'b00;
      set_all('0);
      test_reset();
      test_zeros();
      test_one_hot();
      test_isolation();
      test_same_edge();
      test_width();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
